spi_regfile_peripheral: RTL and testbench
=========================================

SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 Parameter NUM_REGS, default 5, number of DATA_W-bit registers, 1..2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, register and data-phase width, 1..32.
REQ-003 Parameter ADDR_W, default 7, address-phase width, 1..7.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth for sclk/copi/cs_n, minimum 2.
REQ-005 clk  input  1  system clock; all logic in this domain.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sclk  input  1  SPI clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-008 copi  input  1  controller-out data, asynchronous.
REQ-009 cs_n  input  1  chip select, active-low, asynchronous.
REQ-010 cipo  output  1  peripheral-out read data; 0 when not driving.
REQ-011 cipo_oe  output  1  high while synchronised cs_n is low.
REQ-012 regs_flat  output  NUM_REGS*DATA_W  register i at bits [i*DATA_W +: DATA_W].
REQ-013 wr_strobe  output  NUM_REGS  one-clk pulse on bit i when register i is written.
REQ-014 frame_err  output  1  one-clk pulse on aborted frame.

Function
REQ-015 sclk, copi and cs_n each pass through a SYNC_STAGES flop chain; edge detection uses the last two stages only.
REQ-016 Frame = 1 R/W bit (1=write, 0=read), then ADDR_W address bits, then DATA_W data bits, all MSB first; total F = 1+ADDR_W+DATA_W bits.
REQ-017 copi is sampled on each synchronised sclk rising edge while synchronised cs_n is low.
REQ-018 FSM states: IDLE, CMD, ADDR, DATA, DONE.
REQ-019 IDLE -> CMD on synchronised cs_n falling edge; bit counter and shift register cleared.
REQ-020 CMD -> ADDR after 1 sample; ADDR -> DATA after ADDR_W samples; DATA -> DONE after DATA_W samples.
REQ-021 DONE ignores further sclk edges; DONE -> IDLE on synchronised cs_n rising edge, no error.
REQ-022 Synchronised cs_n rising edge in CMD, ADDR or DATA: -> IDLE, no register write, frame_err pulses one clk.
REQ-023 Write commit: on the clk after entering DONE with R/W=1 and address < NUM_REGS, register[address] <= data bits and wr_strobe[address] pulses that same clk.
REQ-024 Write with address >= NUM_REGS: no register change, no strobe, no error.
REQ-025 Read: on the last address sample, register[address] (0 if address >= NUM_REGS) loads the output shift register.
REQ-026 Read: cipo presents data MSB on the first synchronised sclk falling edge after the last address sample, then shifts one bit per falling edge; after DATA_W bits, cipo = 0.
REQ-027 cipo = 0 during CMD/ADDR, during write frames, and whenever cs_n is high.
REQ-028 Registers not addressed by a completed write hold value indefinitely.
REQ-029 Read frames never modify registers or pulse wr_strobe.
REQ-030 sclk frequency is at most clk/8; behaviour above that is undefined.
REQ-031 Back-to-back frames with cs_n high for >= SYNC_STAGES+2 clk are each processed independently.

Reset
REQ-032 rst_n low asynchronously forces: FSM IDLE, all synchroniser flops to idle level (sclk 0, copi 0, cs_n 1), counters 0, regs_flat all 0, wr_strobe 0, frame_err 0, cipo 0, cipo_oe 0.
REQ-033 Reset asserted mid-frame discards the frame; after release, the first action is waiting for a fresh cs_n falling edge, so the remainder of an in-progress frame is ignored.

Verification
REQ-034 Defaults; write frame R/W=1, addr 0x04, data 0xA5 -> regs_flat[39:32]=0xA5, wr_strobe=5'b10000 for exactly one clk, other registers 0.
REQ-035 After REQ-034, read frame addr 0x04 -> controller captures 0xA5 on cipo across 8 data bits, cipo_oe high during frame, registers unchanged.
REQ-036 Write addr 0x10 data 0xFF -> no register change, wr_strobe 0; subsequent read addr 0x10 -> 0x00.
REQ-037 Write addr 0x01 data 0x3C with cs_n deasserted after 10 bits -> frame_err one-clk pulse, register 1 stays 0x00; next full frame writes normally.
REQ-038 Write addr 0x02 data 0x55 followed by 4 extra sclk pulses before cs_n high -> register 2 = 0x55, single strobe, extra pulses ignored.
REQ-039 rst_n pulsed low after 12 bits of a write frame, then frame completes -> no write; all outputs read reset values.

Source files
------------

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing NUM_REGS DATA_W-bit registers. All SPI pins are
// oversampled in the clk domain; each frame is R/W bit, address, data, MSB first.
module spi_regfile_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         cs_n,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SH_W) + 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] warm_q, warm_d;
  logic                   armed_q, armed_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SH_W-1:0]        shift_q, shift_d;
  logic                   rw_q, rw_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   pend_q, pend_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]    wr_strobe_q, wr_strobe_d;
  logic                   frame_err_q, frame_err_d;
  logic                   cipo_q, cipo_d;
  logic                   cipo_oe_q, cipo_oe_d;

  logic                   sclk_rise, sclk_fall, cs_low, cs_fall, cs_rise, copi_s, sample;
  logic [SH_W-1:0]        shift_samp;
  logic [DATA_W-1:0]      rd_word;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    warm_d      = {warm_q[SYNC_STAGES-2:0], 1'b1};

    sclk_rise  = sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
    sclk_fall  = ~sclk_sync_q[SYNC_STAGES-2] & sclk_sync_q[SYNC_STAGES-1];
    cs_low     = ~cs_sync_q[SYNC_STAGES-2];
    cs_fall    = ~cs_sync_q[SYNC_STAGES-2] & cs_sync_q[SYNC_STAGES-1];
    cs_rise    = cs_sync_q[SYNC_STAGES-2] & ~cs_sync_q[SYNC_STAGES-1];
    copi_s     = copi_sync_q[SYNC_STAGES-1];
    sample     = sclk_rise & cs_low;
    shift_samp = (shift_q << 1) | SH_W'(copi_s);

    // After reset a frame may only start once cs_n has been seen high through a
    // fully refreshed synchroniser, so a frame cut by reset is never resumed.
    armed_d = armed_q | (warm_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES-2]);

    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_samp[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_q[i];
    end

    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    pend_d      = 1'b0;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    frame_err_d = 1'b0;
    cipo_d      = 1'b0;
    cipo_oe_d   = cs_low;

    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = CMD;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      CMD, ADDR, DATA: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          if (state_q == DATA && !rw_q) begin
            cipo_d = cipo_q;
            if (sclk_fall) begin
              cipo_d = tx_q[DATA_W-1];
              tx_d   = tx_q << 1;
            end
          end
          if (sample) begin
            shift_d = shift_samp;
            cnt_d   = cnt_q + 1'b1;
            if (state_q == CMD) begin
              rw_d    = copi_s;
              state_d = ADDR;
              cnt_d   = '0;
            end else if (state_q == ADDR) begin
              if (cnt_q == CNT_W'(ADDR_W-1)) begin
                addr_d  = shift_samp[ADDR_W-1:0];
                tx_d    = rd_word;
                state_d = DATA;
                cnt_d   = '0;
              end
            end else if (cnt_q == CNT_W'(DATA_W-1)) begin
              state_d = DONE;
              pend_d  = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Commit one clk after DONE is entered; out-of-range addresses match nothing.
    if (pend_q && rw_q) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_q == ADDR_W'(i)) begin
          regs_d[i]      = shift_q[DATA_W-1:0];
          wr_strobe_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      cs_sync_q   <= '1;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      tx_q        <= '0;
      pend_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      cs_sync_q   <= cs_sync_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      pend_q      <= pend_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;
  assign cipo      = cipo_q;
  assign cipo_oe   = cipo_oe_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral at default parameters: drives mode-0
// SPI frames bit by bit and checks registers, strobes, errors and read-back data.
module tb_spi_regfile_peripheral;

  localparam int NR   = 5;
  localparam int DW   = 8;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          copi = 1'b0;
  logic          cs_n = 1'b1;
  logic          cipo;
  logic          cipo_oe;
  logic [NR*DW-1:0] regs_flat;
  logic [NR-1:0] wr_strobe;
  logic          frame_err;

  spi_regfile_peripheral dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .copi      (copi),
    .cs_n      (cs_n),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Running cycle counts of output activity, sampled on the falling clk edge.
  int strb_cyc [NR] = '{default: 0};
  int ferr_cyc = 0;
  int oe_cyc   = 0;
  int cipo_cyc = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (wr_strobe[i] === 1'b1) strb_cyc[i] <= strb_cyc[i] + 1;
    if (frame_err === 1'b1) ferr_cyc <= ferr_cyc + 1;
    if (cipo_oe === 1'b1)   oe_cyc   <= oe_cyc + 1;
    if (cipo === 1'b1)      cipo_cyc <= cipo_cyc + 1;
  end

  int s_strb [NR];
  int s_ferr, s_oe, s_cipo;

  task automatic snap();
    for (int i = 0; i < NR; i++) s_strb[i] = strb_cyc[i];
    s_ferr = ferr_cyc;
    s_oe   = oe_cyc;
    s_cipo = cipo_cyc;
  endtask

  function automatic int strb_total_delta();
    int t;
    t = 0;
    for (int i = 0; i < NR; i++) t += strb_cyc[i] - s_strb[i];
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                           input int nbits, input int extra, input int rst_at,
                           output logic [7:0] rd);
    logic [15:0] fr;
    fr   = {rw, addr, data};
    rd   = '0;
    cs_n = 1'b0;
    clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      copi = fr[15-i];
      clks(HALF);
      if (i >= 8) rd[15-i] = cipo;
      sclk = 1'b1;
      clks(HALF);
      sclk = 1'b0;
      if (i == rst_at - 1) begin
        rst_n = 1'b0;
        clks(3);
        rst_n = 1'b1;
      end
    end
    for (int k = 0; k < extra; k++) begin
      clks(HALF);
      sclk = 1'b1;
      clks(HALF);
      sclk = 1'b0;
    end
    clks(HALF);
    cs_n = 1'b1;
    copi = 1'b0;
    clks(12);
  endtask

  initial begin
    logic [7:0] rd;

    clks(4);
    rst_n = 1'b1;
    clks(4);
    check("reset_regs",      64'(regs_flat), 64'h0);
    check("reset_strobe",    64'(wr_strobe), 64'h0);
    check("reset_frame_err", 64'(frame_err), 64'h0);
    check("reset_cipo",      64'(cipo),      64'h0);
    check("reset_cipo_oe",   64'(cipo_oe),   64'h0);

    // Write 0xA5 to register 4.
    snap();
    spi_frame(1'b1, 7'h04, 8'hA5, 16, 0, -1, rd);
    check("w4_regs",        64'(regs_flat), 64'hA5_00_00_00_00);
    check("w4_strobe4",     64'(strb_cyc[4] - s_strb[4]), 64'd1);
    check("w4_strobe_all",  64'(strb_total_delta()), 64'd1);
    check("w4_frame_err",   64'(ferr_cyc - s_ferr), 64'd0);
    check("w4_oe_seen",     64'(oe_cyc > s_oe), 64'd1);
    check("w4_cipo_quiet",  64'(cipo_cyc - s_cipo), 64'd0);

    // Read register 4 back.
    snap();
    spi_frame(1'b0, 7'h04, 8'h00, 16, 0, -1, rd);
    check("r4_data",        64'(rd), 64'hA5);
    check("r4_regs",        64'(regs_flat), 64'hA5_00_00_00_00);
    check("r4_strobe_all",  64'(strb_total_delta()), 64'd0);
    check("r4_oe_seen",     64'(oe_cyc > s_oe), 64'd1);

    // Out-of-range write, then out-of-range read.
    snap();
    spi_frame(1'b1, 7'h10, 8'hFF, 16, 0, -1, rd);
    check("w10_regs",       64'(regs_flat), 64'hA5_00_00_00_00);
    check("w10_strobe_all", 64'(strb_total_delta()), 64'd0);
    check("w10_frame_err",  64'(ferr_cyc - s_ferr), 64'd0);
    spi_frame(1'b0, 7'h10, 8'h00, 16, 0, -1, rd);
    check("r10_data",       64'(rd), 64'h00);

    // Frame aborted after 10 bits, then the same write completed.
    snap();
    spi_frame(1'b1, 7'h01, 8'h3C, 10, 0, -1, rd);
    check("abort_frame_err", 64'(ferr_cyc - s_ferr), 64'd1);
    check("abort_regs",      64'(regs_flat), 64'hA5_00_00_00_00);
    check("abort_strobe",    64'(strb_total_delta()), 64'd0);
    snap();
    spi_frame(1'b1, 7'h01, 8'h3C, 16, 0, -1, rd);
    check("w1_regs",         64'(regs_flat), 64'hA5_00_00_3C_00);
    check("w1_strobe1",      64'(strb_cyc[1] - s_strb[1]), 64'd1);
    check("w1_frame_err",    64'(ferr_cyc - s_ferr), 64'd0);

    // Write with four surplus sclk pulses before cs_n rises.
    snap();
    spi_frame(1'b1, 7'h02, 8'h55, 16, 4, -1, rd);
    check("w2x_regs",        64'(regs_flat), 64'hA5_00_55_3C_00);
    check("w2x_strobe2",     64'(strb_cyc[2] - s_strb[2]), 64'd1);
    check("w2x_strobe_all",  64'(strb_total_delta()), 64'd1);
    check("w2x_frame_err",   64'(ferr_cyc - s_ferr), 64'd0);

    snap();
    spi_frame(1'b0, 7'h01, 8'h00, 16, 0, -1, rd);
    check("r1_data",         64'(rd), 64'h3C);
    check("r1_regs",         64'(regs_flat), 64'hA5_00_55_3C_00);

    // Reset pulsed after 12 bits of a write; the rest of the frame is ignored.
    snap();
    spi_frame(1'b1, 7'h03, 8'h77, 16, 0, 12, rd);
    check("rstmid_regs",      64'(regs_flat), 64'h0);
    check("rstmid_strobe",    64'(strb_total_delta()), 64'd0);
    check("rstmid_frame_err", 64'(ferr_cyc - s_ferr), 64'd0);
    check("rstmid_cipo",      64'(cipo), 64'h0);
    check("rstmid_cipo_oe",   64'(cipo_oe), 64'h0);
    check("rstmid_wr_strobe", 64'(wr_strobe), 64'h0);

    // A fresh frame after that reset is processed normally.
    snap();
    spi_frame(1'b1, 7'h00, 8'h81, 16, 0, -1, rd);
    check("w0_regs",          64'(regs_flat), 64'h00_00_00_00_81);
    check("w0_strobe0",       64'(strb_cyc[0] - s_strb[0]), 64'd1);
    check("w0_strobe_all",    64'(strb_total_delta()), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
